// File: rtl/mole_autoplayer.sv
// Whack-a-mole autoplayer: captures a one-hot LED target, toggles the
// matching switch after a reaction delay, then waits for the game to ack.
// Ports: clk, reset (sync, active-high), enable, LED[15:0] in;
//        sw[15:0], busy, hit_count[7:0], timeout out (all registered).
// Option: define MOLE_AUTOPLAYER_JITTER_EN to add 0..7 cycles of
//         LFSR-driven jitter to the reaction delay.
module mole_autoplayer #(
  parameter int unsigned REACT_CYCLES = 4,
  parameter int unsigned ACK_TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] LED,
  output logic [15:0] sw,
  output logic        busy,
  output logic [7:0]  hit_count,
  output logic        timeout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REACT = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam logic [16:0] REACT_LOAD = 17'(REACT_CYCLES - 1);
  localparam logic [15:0] ACK_LAST   = 16'(ACK_TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic [15:0] pat_q, pat_d;
  logic [3:0]  idx_q, idx_d;
  logic [16:0] react_q, react_d;
  logic [15:0] ack_q, ack_d;
  logic [15:0] sw_q, sw_d;
  logic [7:0]  hit_q, hit_d;
  logic        to_q, to_d;
  logic        busy_q;

  logic        led_valid;
  logic [3:0]  led_idx;
  logic [16:0] react_load;

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves 0.
  assign led_valid = (LED != 16'd0) &&
                     ((LED & (LED - 16'd1)) == 16'd0);

  always_comb begin
    led_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (LED[i]) led_idx = 4'(i);
    end
  end

`ifdef MOLE_AUTOPLAYER_JITTER_EN
  logic [7:0] lfsr_q;
  logic       lfsr_fb;

  // Fibonacci taps 8,6,5,4.
  assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= 8'hA5;
    else       lfsr_q <= {lfsr_q[6:0], lfsr_fb};
  end

  assign react_load = REACT_LOAD + {14'd0, lfsr_q[2:0]};
`else
  assign react_load = REACT_LOAD;
`endif

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    idx_d   = idx_q;
    react_d = react_q;
    ack_d   = ack_q;
    sw_d    = sw_q;
    hit_d   = hit_q;
    to_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (enable && led_valid) begin
          pat_d   = LED;
          idx_d   = led_idx;
          react_d = react_load;
          state_d = S_REACT;
        end
      end
      S_REACT: begin
        if ((LED != pat_q) || !enable) begin
          state_d = S_IDLE;
        end else if (react_q == 17'd0) begin
          sw_d[idx_q] = ~sw_q[idx_q];
          ack_d       = 16'd0;
          state_d     = S_WAIT;
        end else begin
          react_d = react_q - 17'd1;
        end
      end
      S_WAIT: begin
        // A moved LED is an ack and wins over a same-cycle timeout.
        if (LED != pat_q) begin
          if (hit_q != 8'hFF) hit_d = hit_q + 8'd1;
          state_d = S_IDLE;
        end else if (ack_q == ACK_LAST) begin
          to_d    = 1'b1;
          state_d = S_IDLE;
        end else begin
          ack_d = ack_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pat_q   <= 16'd0;
      idx_q   <= 4'd0;
      react_q <= 17'd0;
      ack_q   <= 16'd0;
      sw_q    <= 16'd0;
      hit_q   <= 8'd0;
      to_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      idx_q   <= idx_d;
      react_q <= react_d;
      ack_q   <= ack_d;
      sw_q    <= sw_d;
      hit_q   <= hit_d;
      to_q    <= to_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign sw        = sw_q;
  assign busy      = busy_q;
  assign hit_count = hit_q;
  assign timeout   = to_q;

endmodule
